// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin UART transmit scheduler with 8N1 framing.
//
// Ports:
//   clk_in   system clock
//   rst_n    asynchronous active-low reset
//   req      per-requester transmit request, level-sensitive
//   data0    byte from requester 0, latched on its grant edge
//   data1    byte from requester 1, latched on its grant edge
//   grant    one-hot single-cycle pulse marking the cycle the byte was latched
//   busy     high from the grant cycle up to, not including, the done cycle
//   done     single-cycle pulse when the stop bit completes
//   tx       serial line, idle high
//
// Bit timing comes from a baud-enable counter; everything runs on clk_in.

module uart_tx_sched #(
    parameter int unsigned BAUD_DIV = 1736
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            last_q, last_d;
    logic            tx_q, tx_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic bit_end;
    logic winner;

    assign bit_end = (cnt_q == CntMax);
    // On a tie the requester that was not granted last wins; otherwise the sole requester.
    assign winner  = (req == 2'b11) ? ~last_q : req[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b1;
            tx_q    <= 1'b1;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx_d is the line level for the state being entered, so tx
    // is registered yet changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        tx_d    = 1'b1;
        grant_d = 2'b00;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    shift_d = winner ? data1 : data0;
                    last_d  = winner;
                    cnt_d   = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a BAUD_DIV=4 instance for the frame and arbitration
// vectors, plus a BAUD_DIV=1736 instance for full-rate bit timing.

module tb_uart_tx_sched;

    localparam int unsigned BA = 4;
    localparam int unsigned BB = 1736;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_a = 2'b00;
    logic [7:0] d0_a = 8'h00;
    logic [7:0] d1_a = 8'h00;
    logic [1:0] grant_a;
    logic       busy_a, done_a, tx_a;

    logic [1:0] req_b = 2'b00;
    logic [7:0] d0_b = 8'h00;
    logic [1:0] grant_b;
    logic       busy_b, done_b, tx_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.BAUD_DIV(BA)) dut_a (
        .clk_in (clk),
        .rst_n  (rst_n),
        .req    (req_a),
        .data0  (d0_a),
        .data1  (d1_a),
        .grant  (grant_a),
        .busy   (busy_a),
        .done   (done_a),
        .tx     (tx_a)
    );

    uart_tx_sched #(.BAUD_DIV(BB)) dut_b (
        .clk_in (clk),
        .rst_n  (rst_n),
        .req    (req_b),
        .data0  (d0_b),
        .data1  (8'h00),
        .grant  (grant_b),
        .busy   (busy_b),
        .done   (done_b),
        .tx     (tx_b)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_grant;
        logic [7:0] exp_byte;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected line level j cycles after the grant edge of a frame carrying b.
    function automatic logic exp_tx(input logic [7:0] b, input int j, input int unsigned div);
        int n;
        n = j / int'(div);
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return b[n-1];
    endfunction

    // Waits (bounded) for a grant on dut_a, then checks the whole frame cycle by cycle.
    // Returns on the negedge of the done cycle.
    task automatic watch_a(input logic [1:0] exp_g, input logic [7:0] exp_byte, input bit drop,
                           input logic [1:0] mid_req, input bit chg_d0, input logic [7:0] new_d0,
                           input string tag);
        int waited = 0;
        int errs = 0;
        logic [7:0] cap = 8'h00;
        while (grant_a == 2'b00 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_wait"}, waited, 1);
        if (waited >= 50) return;
        check({tag, "_grant_busy"}, {grant_a, busy_a}, {exp_g, 1'b1});
        for (int j = 0; j < 10 * int'(BA); j++) begin
            if (tx_a !== exp_tx(exp_byte, j, BA) || busy_a !== 1'b1 || done_a !== 1'b0 ||
                (j > 0 && grant_a !== 2'b00)) errs++;
            if ((j % int'(BA)) == int'(BA / 2) && j / int'(BA) >= 1 && j / int'(BA) <= 8)
                cap[j / int'(BA) - 1] = tx_a;
            if (j == 0 && drop) req_a = 2'b00;
            if (j == 1 && chg_d0) d0_a = new_d0;
            if (j == 3 * int'(BA) && mid_req != 2'b00) req_a = mid_req;
            @(negedge clk);
        end
        check({tag, "_byte"}, cap, exp_byte);
        check({tag, "_wave"}, errs, 0);
        check({tag, "_end"}, {done_a, busy_a, tx_a, grant_a}, {1'b1, 1'b0, 1'b1, 2'b00});
    endtask

    vec_t tbl[7];

    initial begin
        int errs;
        int waited;

        tbl[0] = '{2'b01, 8'h55, 8'h00, 2'b01, 8'h55};
        tbl[1] = '{2'b10, 8'h00, 8'hC3, 2'b10, 8'hC3};
        tbl[2] = '{2'b11, 8'hA5, 8'h3C, 2'b01, 8'hA5};
        tbl[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};
        tbl[4] = '{2'b11, 8'h77, 8'h88, 2'b01, 8'h77};
        tbl[5] = '{2'b01, 8'hFF, 8'h00, 2'b01, 8'hFF};
        tbl[6] = '{2'b11, 8'h12, 8'h34, 2'b10, 8'h34};

        // Reset state
        #12;
        check("reset_a", {tx_a, grant_a, busy_a, done_a}, {1'b1, 2'b00, 1'b0, 1'b0});
        check("reset_b", {tx_b, grant_b, busy_b, done_b}, {1'b1, 2'b00, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table: round-robin and frame content, starting from last=1
        for (int i = 0; i < 7; i++) begin
            req_a = tbl[i].req;
            d0_a  = tbl[i].d0;
            d1_a  = tbl[i].d1;
            watch_a(tbl[i].exp_grant, tbl[i].exp_byte, 1'b1, 2'b00, 1'b0, 8'h00,
                    $sformatf("vec%0d", i));
        end

        // data0 changes one cycle after grant; frame keeps the latched byte
        req_a = 2'b01;
        d0_a  = 8'h0F;
        watch_a(2'b01, 8'h0F, 1'b1, 2'b00, 1'b1, 8'hF0, "data_hold");

        // Requester 1 raises mid-frame: held off until after done
        req_a = 2'b01;
        d0_a  = 8'h5A;
        d1_a  = 8'hC7;
        watch_a(2'b01, 8'h5A, 1'b1, 2'b10, 1'b0, 8'h00, "mid_req0");
        watch_a(2'b10, 8'hC7, 1'b1, 2'b00, 1'b0, 8'h00, "mid_req1");

        // Reset mid-DATA of a 0x00 frame
        @(negedge clk);
        req_a  = 2'b01;
        d0_a   = 8'h00;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (grant_a == 2'b00 && waited < 50);
        check("rst_mid_grant", grant_a, 2'b01);
        req_a = 2'b00;
        repeat (2 * BA + 1) @(negedge clk);
        check("rst_mid_pre", {tx_a, busy_a}, {1'b0, 1'b1});
        #1 rst_n = 1'b0;
        #1 check("rst_mid_async", {tx_a, busy_a, grant_a, done_a}, {1'b1, 1'b0, 2'b00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || grant_a !== 2'b00 || done_a !== 1'b0) errs++;
        end
        check("rst_mid_quiet", errs, 0);

        // Both requests held high from reset: grants 01, 10, 01 back to back
        rst_n = 1'b0;
        req_a = 2'b11;
        d0_a  = 8'hA5;
        d1_a  = 8'h3C;
        @(negedge clk);
        rst_n = 1'b1;
        watch_a(2'b01, 8'hA5, 1'b0, 2'b00, 1'b0, 8'h00, "held0");
        watch_a(2'b10, 8'h3C, 1'b0, 2'b00, 1'b0, 8'h00, "held1");
        watch_a(2'b01, 8'hA5, 1'b1, 2'b00, 1'b0, 8'h00, "held2");

        // Full-rate divider: 0x41, every bit held exactly 1736 cycles
        @(negedge clk);
        req_b = 2'b01;
        d0_b  = 8'h41;
        @(negedge clk);
        check("slow_grant", {grant_b, busy_b, tx_b}, {2'b01, 1'b1, 1'b0});
        req_b = 2'b00;
        errs = 0;
        for (int j = 0; j < 10 * int'(BB); j++) begin
            if (tx_b !== exp_tx(8'h41, j, BB) || busy_b !== 1'b1 || done_b !== 1'b0) errs++;
            @(negedge clk);
        end
        check("slow_wave", errs, 0);
        check("slow_done", {done_b, busy_b, tx_b}, {1'b1, 1'b0, 1'b1});
        @(negedge clk);
        check("slow_done_pulse", {done_b, grant_b}, {1'b0, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester UART transmit scheduler for the Arty-A7 200 MHz design. It arbitrates two byte sources onto a single serial TX line with a round-robin policy, then frames the granted byte as 8N1. Bit timing comes from an internal baud-enable counter, so the whole block runs in one clock domain and uses no derived clocks.

## Interface
Parameters:
- BAUD_DIV, 1736, clk_in cycles per serial bit (200 MHz / 115200). Legal range is 2 to 2^16-1.

Ports:
- clk_in  input  1  system clock, 200 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  per-requester transmit request, level-sensitive.
- data0  input  8  byte from requester 0; sampled only on the grant edge.
- data1  input  8  byte from requester 1; sampled only on the grant edge.
- grant  output  2  one-hot, single-cycle pulse; marks the cycle the requester's byte was latched.
- busy  output  1  high from the grant cycle up to, but not including, the done cycle.
- done  output  1  single-cycle pulse when the stop bit completes.
- tx  output  1  serial line, idle high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If req != 0 at a clock edge, arbitrate, pulse grant, latch the winner's byte into the shift register, clear the baud counter, and go to START.
- Arbitration:
  - A 1-bit pointer `last` records the most recently granted requester.
  - Single request: that requester wins.
  - Both requesting: the requester != last wins.
  - After reset, last=1, so requester 0 wins the first tie.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps to 0.
  - bit_end = (count == BAUD_DIV-1). Each state advances only on bit_end.
  - Counter width is clog2(BAUD_DIV).
- START: tx=0 for one bit, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0]; shift right on bit_end, so data goes out LSB first.
  - Bit index 0..7. On bit_end with index 7, go to STOP.
- STOP: tx=1 for one bit. On bit_end, go to IDLE and pulse done.
- IDLE never grants in the same cycle as done. The line therefore has at least one idle cycle between frames.
- Requester protocol:
  - A requester drops req in the cycle after seeing grant.
  - A req still high after the frame is treated as a new request.
  - Dropping req before grant cancels the request with no side effects.
- data0 and data1 may change freely after grant without affecting the frame in flight.
- All outputs are registered.

## Timing
- Reset values (asynchronous, applied immediately, including mid-frame): tx=1, grant=0, busy=0, done=0, state=IDLE, counter=0, last=1. A frame interrupted by reset is abandoned, not resumed.
- Latency from a req sampled at edge k in IDLE:
  - grant=1 and busy=1 during cycle k+1.
  - tx falls at edge k. tx is a registered output, so it shows low from cycle k+1.
- Bit n (start=0, data=1..8, stop=9) occupies edges k+n·BAUD_DIV through k+(n+1)·BAUD_DIV-1.
- Frame length:
  - done=1 and busy=0 in the cycle after edge k+10·BAUD_DIV.
  - The earliest next grant is at edge k+10·BAUD_DIV+1.
- grant and done are each exactly one cycle wide and are never high in the same cycle.
- req arriving during START, DATA or STOP is held off. It is arbitrated at the first IDLE edge after done.

## Test plan
- BAUD_DIV=4, data0=0x55, req=01 → grant=01 for one cycle; tx = 0, then 1,0,1,0,1,0,1,0, then 1, each level held 4 cycles; done after 40 cycles.
- BAUD_DIV=4, both req held high from reset, data0=0xA5, data1=0x3C → grant order 01, 10, 01; tx frames carry 0xA5, 0x3C, 0xA5; at least 1 idle cycle between frames.
- req=10 raised during an active frame from requester 0 → no grant until the cycle after done; then grant=10.
- Assert rst_n=0 mid-DATA of a 0x00 frame → tx=1 and busy=0 immediately; after release, no transmission without a new req.
- Change data0 from 0x0F to 0xF0 one cycle after grant → the transmitted byte is 0x0F.
- BAUD_DIV=1736, single byte 0x41 → each bit held exactly 1736 cycles; done at cycle 17360 after grant edge.
